led_toggle_fsm: RTL and testbench



---
 rtl/led_toggle_pkg.sv | 18 +
 rtl/led_toggle_fsm.sv | 44 ++++
 tb/tb_led_toggle_fsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/led_toggle_pkg.sv
// rtl/led_toggle_pkg.sv - state encoding and LED decode for the two-press LED toggle FSM
package led_toggle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_ON   = 3'd3,
      ST_F0   = 3'd4,
      ST_F1   = 3'd5
   } state_t;

   // LED is lit in every state of the turn-off half of the sequence
   function automatic logic led_on(input state_t s);
      return (s == ST_ON) || (s == ST_F0) || (s == ST_F1);
   endfunction

endpackage

// File: rtl/led_toggle_fsm.sv
// rtl/led_toggle_fsm.sv - Moore FSM: two C presses light the LED, two B presses clear it, A aborts
module led_toggle_fsm
   import led_toggle_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic A,
   input  logic B,
   input  logic C,
   output logic LED
);

   state_t r_state;
   state_t w_next;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = ST_IDLE;
      if (A) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_next = C ? ST_S0 : ST_IDLE;
            ST_S0:   w_next = C ? ST_S0 : ST_S1;
            ST_S1:   w_next = C ? ST_ON : ST_S1;
            ST_ON:   w_next = B ? ST_F0 : ST_ON;
            ST_F0:   w_next = B ? ST_F0 : ST_F1;
            ST_F1:   w_next = B ? ST_IDLE : ST_F1;
            // unused encodings recover to IDLE
            default: w_next = ST_IDLE;
         endcase
      end
   end

   assign LED = led_on(r_state);

endmodule

// File: tb/tb_led_toggle_fsm.sv
// tb/tb_led_toggle_fsm.sv - self-checking bench for led_toggle_fsm against a press-counting model
module tb_led_toggle_fsm;

   logic CLK;
   logic RST;
   logic A;
   logic B;
   logic C;
   logic LED;

   int n_checks;
   int n_pass;

   // Reference model: LED level plus progress through the current two-press gesture
   logic m_led;
   logic m_seen;
   logic m_released;

   led_toggle_fsm dut (
      .CLK (CLK),
      .RST (RST),
      .A   (A),
      .B   (B),
      .C   (C),
      .LED (LED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: LED got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rst, input logic a, input logic b, input logic c);
      logic btn;
      btn = m_led ? b : c;
      if (rst || a) begin
         m_led      = 1'b0;
         m_seen     = 1'b0;
         m_released = 1'b0;
      end else if (!m_seen) begin
         if (btn) m_seen = 1'b1;
      end else if (!m_released) begin
         if (!btn) m_released = 1'b1;
      end else if (btn) begin
         m_led      = ~m_led;
         m_seen     = 1'b0;
         m_released = 1'b0;
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic a, input logic b,
                       input logic c);
      RST = rst;
      A   = a;
      B   = b;
      C   = c;
      @(posedge CLK);
      model_edge(rst, a, b, c);
      #1;
      check(tag, LED, m_led);
   endtask

   // Runs a C (or B) press sequence given as a bit vector, MSB first
   task automatic press_c(input string tag, input logic [7:0] seq, input int len);
      for (int i = len - 1; i >= 0; i--) step(tag, 1'b0, 1'b0, 1'b0, seq[i]);
   endtask

   task automatic press_b(input string tag, input logic [7:0] seq, input int len);
      for (int i = len - 1; i >= 0; i--) step(tag, 1'b0, 1'b0, seq[i], 1'b0);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      m_led      = 1'b0;
      m_seen     = 1'b0;
      m_released = 1'b0;
      RST = 1'b0;
      A   = 1'b0;
      B   = 1'b0;
      C   = 1'b0;
      #2;

      step("reset", 1'b1, 1'b0, 1'b1, 1'b1);
      check("reset_const", LED, 1'b0);

      press_c("turn_on", 8'b101, 3);
      check("turn_on_lit", LED, 1'b1);
      step("on_hold", 1'b0, 1'b0, 1'b0, 1'b0);

      press_b("turn_off", 8'b101, 3);
      check("turn_off_dark", LED, 1'b0);
      press_b("b_ignored_idle", 8'b01, 2);

      press_c("held_c", 8'b11101, 5);
      check("held_c_lit", LED, 1'b1);
      step("abort_on", 1'b0, 1'b1, 1'b0, 1'b0);
      check("abort_on_dark", LED, 1'b0);

      press_c("to_s1", 8'b10, 2);
      step("abort_s1", 1'b0, 1'b1, 1'b0, 1'b1);
      step("after_abort_c0", 1'b0, 1'b0, 1'b0, 1'b0);
      step("after_abort_c1", 1'b0, 1'b0, 1'b0, 1'b1);
      check("abort_no_credit", LED, 1'b0);
      press_c("full_after_abort", 8'b01, 2);
      check("relit_after_abort", LED, 1'b1);

      press_b("off_again", 8'b101, 3);
      step("s0_entry", 1'b0, 1'b0, 1'b0, 1'b1);
      step("s0_b_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
      press_c("s0_finish", 8'b01, 2);
      check("s0_b_lit", LED, 1'b1);
      press_c("on_c_ignored", 8'b101, 3);
      check("on_c_lit", LED, 1'b1);

      press_b("to_f1", 8'b10, 2);
      step("reset_f1", 1'b1, 1'b0, 1'b1, 1'b0);
      check("reset_f1_dark", LED, 1'b0);
      step("reset_f1_b", 1'b0, 1'b0, 1'b1, 1'b0);
      check("reset_f1_idle", LED, 1'b0);

      for (int i = 0; i < 600; i++) begin
         step("random",
              ($urandom_range(0, 47) == 0),
              ($urandom_range(0, 19) == 0),
              $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
